ram_16x8_prog: RTL and testbench
================================

Name: ram_16x8_prog

Overview:
- 16-word x 8-bit RAM that consumes the address and programming-mode signal from the memory address register.
- Run mode: loads a word from the CPU bus, or drives a word onto it, under control-word enables.
- Programming mode: writes the data DIP switch value to the selected address when the debounced program pushbutton is pressed.
- Sits between the MAR and the shared 8-bit bus.

Parameters:
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width.
- DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles needed to accept a button press (min 1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- prog  input  1  programming mode from MAR; 1 = program, 0 = run.
- addr  input  ADDR_WIDTH  word address from MAR.
- prog_sw  input  DATA_WIDTH  data DIP switches (static during programming).
- prog_wr_btn  input  1  raw, asynchronous, bouncing write pushbutton, active-high.
- bus_in  input  DATA_WIDTH  CPU bus value.
- ram_in  input  1  run-mode load enable, active-high.
- ram_out  input  1  run-mode output enable, active-high.
- bus_out  output  DATA_WIDTH  word at addr (combinational read).
- bus_oe  output  1  bus drive request = ram_out & ~prog.
- prog_busy  output  1  high while the programming FSM is not IDLE.
- prog_done  output  1  one-cycle pulse, the cycle after a programming write.

Behaviour:
- Reset (clr_n=0, async):
  - All words cleared to 0.
  - FSM to IDLE, synchronizer and debounce counter cleared.
  - prog_busy=0, prog_done=0.
  - bus_out shows mem[addr] = 0; bus_oe follows its combinational equation.
- Button synchronizer: 2 flops on prog_wr_btn. btn_s is the second-stage output. 2-cycle latency from the raw input.
- Run mode (prog=0):
  - ram_in=1 at rising edge: mem[addr] <= bus_in.
  - bus_out = mem[addr] combinational, so reads are read-before-write within a cycle.
  - ram_in and ram_out both high: legal. bus_out shows old data until the edge, new data after.
  - The programming FSM is forced to IDLE.
- Programming mode (prog=1): ram_in is ignored, and bus_oe=0 regardless of ram_out.
- Programming FSM:
  - IDLE: if prog & btn_s, go to DEBOUNCE and load cnt=1.
  - DEBOUNCE:
    - btn_s=0: go to IDLE, no write.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES: go to WRITE.
    - otherwise cnt++.
  - WRITE: one cycle. mem[addr] <= prog_sw at the exit edge, then go to WAIT_RELEASE. prog_done=1 during the following cycle.
  - WAIT_RELEASE: stay until btn_s=0, then go to IDLE. Exactly one write per press, even if the button is held.
- prog falling in any non-IDLE state:
  - Immediate return to IDLE at the next edge.
  - No write occurs if WRITE was not yet reached.
  - prog_done is not generated.
- prog_busy = (state != IDLE), registered state decode.
- addr or prog_sw changing during DEBOUNCE: the write uses the values present in the WRITE cycle.
- Reset asserted mid-FSM: abort immediately; memory cleared.

Optional Feature:
- Macro RAM_PROG_AUTOINC_EN.
- Defined:
  - Adds output prog_ptr [ADDR_WIDTH-1:0] and an internal pointer, reset to 0.
  - Programming writes use prog_ptr instead of addr.
  - prog_ptr increments on each WRITE and wraps 15 -> 0.
  - prog_ptr clears to 0 on the cycle after prog rises.
  - Run mode still uses addr.
- Not defined: no prog_ptr port; programming writes use addr.

Test Plan:
- Reset, then run-mode read: clr_n pulse low, prog=0, ram_out=1, addr=5 -> bus_out=8'h00, bus_oe=1.
- Run-mode write then read: addr=3, bus_in=8'hA5, ram_in=1 for 1 cycle -> bus_out=8'hA5 after the edge. ram_in=1 with prog=1 -> mem[3] unchanged.
- Debounced programming: prog=1, addr=7, prog_sw=8'h3C, btn high for 20 cycles with a 2-cycle bounce pulse first:
  - bounce -> no write;
  - clean press -> mem[7]=8'h3C, exactly one prog_done pulse, prog_busy high until release;
  - bus_oe=0 throughout.
- Abort: press btn, drop prog during DEBOUNCE -> FSM to IDLE, mem[addr] unchanged, no prog_done.
- Reset mid-operation: clr_n low in WAIT_RELEASE -> prog_busy=0 immediately, all words 0.
- RAM_PROG_AUTOINC_EN: three presses with prog_sw=11,22,33 -> mem[0..2]=11,22,33, prog_ptr=3. Sixteen further presses -> wrap, prog_ptr=3 again.

Source files
------------

// File: rtl/ram_16x8_prog.sv
// ram_16x8_prog: 16x8 RAM between the MAR and the shared CPU bus.
// Run mode loads/drives the bus under control-word enables; programming
// mode writes the DIP-switch value on a debounced pushbutton press.
// Optional feature macro RAM_PROG_AUTOINC_EN: programming writes go to an
// auto-incrementing pointer (exported as prog_ptr) instead of addr.
module ram_16x8_prog #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  prog,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] prog_sw,
  input  logic                  prog_wr_btn,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  ram_in,
  input  logic                  ram_out,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
`ifdef RAM_PROG_AUTOINC_EN
  output logic [ADDR_WIDTH-1:0] prog_ptr,
`endif
  output logic                  prog_busy,
  output logic                  prog_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WRITE        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_sync1;
  logic                  r_btn_s;
  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_done;
  logic                  w_prog_wr;
  logic                  w_run_wr;
  logic [ADDR_WIDTH-1:0] w_prog_addr;

`ifdef RAM_PROG_AUTOINC_EN
  logic                  r_prog_d;
  logic [ADDR_WIDTH-1:0] r_ptr;

  // Programming pointer: cleared the cycle after prog rises, bumped per write
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_prog_d <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_prog_d <= prog;
      if (prog && !r_prog_d)
        r_ptr <= '0;
      else if (w_prog_wr)
        r_ptr <= r_ptr + 1'b1;
    end
  end

  assign w_prog_addr = r_ptr;
  assign prog_ptr    = r_ptr;
`else
  assign w_prog_addr = addr;
`endif

  // Two-flop synchronizer for the raw asynchronous pushbutton
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= prog_wr_btn;
      r_btn_s <= r_sync1;
    end
  end

  // FSM state register and debounce counter
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; leaving programming mode aborts from any state
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    if (!prog) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_btn_s) begin
            w_next    = DEBOUNCE;
            w_cnt_nxt = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!r_btn_s)
            w_next = IDLE;
          else if (r_cnt == CNT_MAX)
            w_next = WRITE;
          else
            w_cnt_nxt = r_cnt + 1'b1;
        end
        WRITE:        w_next = WAIT_RELEASE;
        WAIT_RELEASE: if (!r_btn_s) w_next = IDLE;
        default:      w_next = IDLE;
      endcase
    end
  end

  // FSM outputs: a programming write only happens if still in program mode
  always_comb begin
    w_prog_wr = (r_state == WRITE) && prog;
    w_run_wr  = ram_in && !prog;
  end

  // prog_done pulses in the cycle following the programming write
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_done <= 1'b0;
    else        r_done <= w_prog_wr;
  end

  // Memory array: run-mode bus load or programming write, cleared on reset
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_run_wr) begin
      r_mem[addr] <= bus_in;
    end else if (w_prog_wr) begin
      r_mem[w_prog_addr] <= prog_sw;
    end
  end

  assign bus_out   = r_mem[addr];
  assign bus_oe    = ram_out && !prog;
  assign prog_busy = (r_state != IDLE);
  assign prog_done = r_done;

endmodule

// File: tb/tb_ram_16x8_prog.sv
// Self-checking bench for ram_16x8_prog: table-driven run-mode vectors with a
// scoreboard queue, plus hand-written programming, abort and reset sequences.
module tb_ram_16x8_prog;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       prog;
  logic [3:0] addr;
  logic [7:0] prog_sw;
  logic       prog_wr_btn;
  logic [7:0] bus_in;
  logic       ram_in;
  logic       ram_out;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       prog_busy;
  logic       prog_done;
`ifdef RAM_PROG_AUTOINC_EN
  logic [3:0] prog_ptr;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int oe_bad   = 0;
  logic [7:0] sb_q [$];

  ram_16x8_prog dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .prog        (prog),
    .addr        (addr),
    .prog_sw     (prog_sw),
    .prog_wr_btn (prog_wr_btn),
    .bus_in      (bus_in),
    .ram_in      (ram_in),
    .ram_out     (ram_out),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
`ifdef RAM_PROG_AUTOINC_EN
    .prog_ptr    (prog_ptr),
`endif
    .prog_busy   (prog_busy),
    .prog_done   (prog_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       prog;
    logic [3:0] addr;
    logic [7:0] bus_in;
    logic       ram_in;
    logic       ram_out;
    logic [7:0] exp_pre;
    logic [7:0] exp_post;
    logic       exp_oe;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the edge and tally pulses/violations
  task automatic tick();
    @(posedge clk);
    #1;
    if (prog_done === 1'b1) done_cnt++;
    if (prog === 1'b1 && bus_oe !== 1'b0) oe_bad++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [7:0] sw);
    prog_sw     = sw;
    prog_wr_btn = 1'b1;
    ticks(10);
    prog_wr_btn = 1'b0;
    ticks(4);
  endtask

  logic [3:0] waddr;

  initial begin
    vecs[0] = '{1'b0, 4'd5,  8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 4'd3,  8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
    vecs[2] = '{1'b0, 4'd3,  8'h00, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1};
    vecs[3] = '{1'b1, 4'd3,  8'h5A, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0};
    vecs[4] = '{1'b0, 4'd3,  8'h5A, 1'b1, 1'b1, 8'hA5, 8'h5A, 1'b1};
    vecs[5] = '{1'b0, 4'd15, 8'hFF, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1};
    vecs[6] = '{1'b0, 4'd0,  8'h81, 1'b1, 1'b0, 8'h00, 8'h81, 1'b0};
    vecs[7] = '{1'b0, 4'd15, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1};
    vecs[8] = '{1'b0, 4'd3,  8'h00, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b1};

    clr_n = 1'b0; prog = 1'b0; addr = 4'd5; prog_sw = 8'h00;
    prog_wr_btn = 1'b0; bus_in = 8'h00; ram_in = 1'b0; ram_out = 1'b1;
    #12;
    check("rst_bus_out", bus_out, 8'h00);
    check("rst_bus_oe", bus_oe, 1'b1);
    check("rst_busy", prog_busy, 1'b0);
    check("rst_done", prog_done, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    ticks(1);

    // Run-mode table: check pre-edge values, queue the post-edge expectation
    for (int i = 0; i < 9; i++) begin
      prog = vecs[i].prog; addr = vecs[i].addr; bus_in = vecs[i].bus_in;
      ram_in = vecs[i].ram_in; ram_out = vecs[i].ram_out;
      #1;
      check($sformatf("vec%0d_pre", i), bus_out, vecs[i].exp_pre);
      check($sformatf("vec%0d_oe", i), bus_oe, vecs[i].exp_oe);
      sb_q.push_back(vecs[i].exp_post);
      tick();
      ram_in = 1'b0;
      #1;
      if (sb_q.size() == 0) check($sformatf("vec%0d_sb_empty", i), 1, 0);
      else check($sformatf("vec%0d_post", i), bus_out, sb_q.pop_front());
    end

    // Debounced programming: bounce first, then a clean 20-cycle press
`ifdef RAM_PROG_AUTOINC_EN
    waddr = 4'd0;
`else
    waddr = 4'd7;
`endif
    prog = 1'b1; addr = 4'd7; prog_sw = 8'h3C; ram_in = 1'b0; ram_out = 1'b1;
    done_cnt = 0; oe_bad = 0;
    tick();
    prog_wr_btn = 1'b1;
    ticks(2);
    prog_wr_btn = 1'b0;
    ticks(6);
    addr = waddr; #1;
    check("bounce_no_write", bus_out, 8'h00);
    check("bounce_no_done", done_cnt, 0);
    check("bounce_idle", prog_busy, 1'b0);
    addr = 4'd7;
    prog_wr_btn = 1'b1;
    ticks(20);
    check("held_busy", prog_busy, 1'b1);
    prog_wr_btn = 1'b0;
    ticks(5);
    check("prog_done_once", done_cnt, 1);
    check("release_idle", prog_busy, 1'b0);
    addr = waddr; #1;
    check("prog_write", bus_out, 8'h3C);
    check("prog_oe_low", oe_bad, 0);

    // Abort: drop prog during DEBOUNCE
`ifdef RAM_PROG_AUTOINC_EN
    waddr = 4'd1;
`else
    waddr = 4'd9;
`endif
    addr = 4'd9; prog_sw = 8'h77; done_cnt = 0;
    prog_wr_btn = 1'b1;
    ticks(4);
    check("abort_in_debounce", prog_busy, 1'b1);
    prog = 1'b0; prog_wr_btn = 1'b0;
    tick();
    check("abort_idle", prog_busy, 1'b0);
    ticks(8);
    addr = waddr; #1;
    check("abort_no_write", bus_out, 8'h00);
    check("abort_no_done", done_cnt, 0);

    // Reset while in WAIT_RELEASE
`ifdef RAM_PROG_AUTOINC_EN
    waddr = 4'd0;
`else
    waddr = 4'd4;
`endif
    prog = 1'b1; addr = 4'd4; prog_sw = 8'h99; done_cnt = 0;
    tick();
    prog_wr_btn = 1'b1;
    ticks(12);
    addr = waddr; #1;
    check("rst_mid_written", bus_out, 8'h99);
    check("rst_mid_busy", prog_busy, 1'b1);
    #1;
    clr_n = 1'b0;
    #1;
    check("rst_mid_busy_clr", prog_busy, 1'b0);
    check("rst_mid_mem_clr", bus_out, 8'h00);
    addr = 4'd3; #1;
    check("rst_mid_mem3_clr", bus_out, 8'h00);
    prog_wr_btn = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    ticks(2);
    check("rst_mid_stays_idle", prog_busy, 1'b0);

`ifdef RAM_PROG_AUTOINC_EN
    // Auto-increment: three presses, then sixteen more to wrap
    prog = 1'b0; tick();
    prog = 1'b1; tick();
    check("ptr_cleared", prog_ptr, 4'd0);
    press(8'h11); press(8'h22); press(8'h33);
    check("ptr_after3", prog_ptr, 4'd3);
    addr = 4'd0; #1; check("auto_mem0", bus_out, 8'h11);
    addr = 4'd1; #1; check("auto_mem1", bus_out, 8'h22);
    addr = 4'd2; #1; check("auto_mem2", bus_out, 8'h33);
    for (int i = 0; i < 16; i++) press(8'h40 + 8'(i));
    check("ptr_wrap", prog_ptr, 4'd3);
    addr = 4'd2; #1; check("auto_wrap_mem2", bus_out, 8'h4F);
    addr = 4'd3; #1; check("auto_wrap_mem3", bus_out, 8'h40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
